// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// byte/word geometry and the big-endian byte insertion helper.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } loaderState_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W         = 8;
   localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
   localparam int IDX_W          = 2;

   // Byte k of a word lands in the k-th most significant byte lane (MSB-first).
   function automatic logic [WORD_W-1:0] insertByte(input logic [WORD_W-1:0] word,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic [BYTE_W-1:0] data);
      logic [WORD_W-1:0] result;
      result = word;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         if (idx == IDX_W'(k)) begin
            result[WORD_W-1-BYTE_W*k -: BYTE_W] = data;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects accepted bytes into a 32-bit word; flags completion on the fourth
// byte or on an early last byte, in which case the unfilled lanes read as zero.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              accept,
   input  logic [BYTE_W-1:0] data,
   input  logic              last,
   output logic              wordReady,
   output logic [WORD_W-1:0] packedWord,
   output logic [IDX_W-1:0]  byteIdx
);

   logic [WORD_W-1:0] wordReg;

   // Starting a new word from zero makes zero-fill of a short final word free.
   always_comb begin
      packedWord = insertByte((byteIdx == '0) ? '0 : wordReg, byteIdx, data);
      wordReady  = accept && (last || (byteIdx == IDX_W'(BYTES_PER_WORD-1)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byteIdx <= '0;
         wordReg <= '0;
      end else if (clear) begin
         byteIdx <= '0;
         wordReg <= '0;
      end else if (accept) begin
         if (wordReady) begin
            byteIdx <= '0;
            wordReg <= '0;
         end else begin
            byteIdx <= byteIdx + 1'b1;
            wordReg <= packedWord;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: streams image bytes into instruction memory as packed
// words and holds the core in reset until the image has landed cleanly.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   input  logic [BYTE_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   input  logic              reload,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

   loaderState_e      state;
   logic              atTop;
   logic              endPending;
   logic              endIsError;
   logic              accept;
   logic              packAccept;
   logic              wordReady;
   logic [WORD_W-1:0] packedWord;
   logic [IDX_W-1:0]  byteIdx;

   assign accept     = s_valid && s_ready;
   assign packAccept = accept && !atTop;

   byte_packer packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (reload),
      .accept     (packAccept),
      .data       (s_data),
      .last       (s_last),
      .wordReady  (wordReady),
      .packedWord (packedWord),
      .byteIdx    (byteIdx)
   );

   // Loader FSM. The address advances the edge after each write strobe and
   // parks at the top of memory so a further byte is an overflow, never a wrap.
   // s_ready drops as soon as the final byte is taken so nothing sneaks in
   // during the closing write cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= LOAD;
         s_ready    <= 1'b1;
         wr_en      <= 1'b0;
         wr_addr    <= BASE;
         wr_data    <= '0;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         atTop      <= 1'b0;
         endPending <= 1'b0;
         endIsError <= 1'b0;
      end else if (reload) begin
         state      <= LOAD;
         s_ready    <= 1'b1;
         wr_en      <= 1'b0;
         wr_addr    <= BASE;
         wr_data    <= '0;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         atTop      <= 1'b0;
         endPending <= 1'b0;
         endIsError <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (wr_en) begin
            word_count <= word_count + 1'b1;
            if (!atTop) begin
               wr_addr <= wr_addr + 1'b1;
            end
         end
         case (state)
            LOAD: begin
               if (endPending) begin
                  endPending <= 1'b0;
                  if (endIsError) begin
                     state <= ERR;
                     error <= 1'b1;
                  end else begin
                     state     <= RUN;
                     cpu_reset <= 1'b0;
                     done      <= 1'b1;
                  end
               end else if (accept) begin
                  if (atTop) begin
                     state   <= ERR;
                     error   <= 1'b1;
                     s_ready <= 1'b0;
                  end else if (wordReady) begin
                     wr_en   <= 1'b1;
                     wr_data <= packedWord;
                     if (wr_addr == TOP_ADDR) begin
                        atTop <= 1'b1;
                     end
                     if (s_last) begin
                        s_ready    <= 1'b0;
                        endPending <= 1'b1;
                        endIsError <= (byteIdx != IDX_W'(BYTES_PER_WORD-1));
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
